// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Opcode constants and arbiter FSM state type.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first set request
// at or after ptr, wrapping; reusable for any shared resource.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  always_comb begin
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    any   = |req;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ requesters.
// Define ALU_ARB_STATS_EN to add per-requester Grant_Count counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NREQ-1:0]          Req_Valid,
  output logic [NREQ-1:0]          Req_Ready,
  input  logic [NREQ*WIDTH-1:0]    Req_A,
  input  logic [NREQ*WIDTH-1:0]    Req_B,
  input  logic [NREQ*3-1:0]        Req_Opcode,
  output logic [WIDTH-1:0]         Alu_A,
  output logic [WIDTH-1:0]         Alu_B,
  output logic [2:0]               Alu_Opcode,
  input  logic [WIDTH-1:0]         Alu_Result,
  input  logic                     Alu_Zero,
  input  logic                     Alu_Carry,
  output logic                     Rsp_Valid,
  input  logic                     Rsp_Ready,
  output logic [$clog2(NREQ)-1:0]  Rsp_Id,
  output logic [WIDTH-1:0]         Rsp_Result,
  output logic                     Rsp_Zero,
  output logic                     Rsp_Carry
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*8-1:0]        Grant_Count
`endif
);

  localparam int IW = $clog2(NREQ);

  arb_state_t       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic             z_q;
  logic             c_q;

  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    idx;
  logic             any;
  logic             accept;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr (
    .req(Req_Valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );

  // Ready is suppressed while reset is asserted
  assign accept    = Rst_n && (state == IDLE) && any;
  assign Req_Ready = accept ? gnt : '0;

  assign Alu_A      = a_q;
  assign Alu_B      = b_q;
  assign Alu_Opcode = op_q;

  assign Rsp_Valid  = (state == RESP);
  assign Rsp_Id     = id_q;
  assign Rsp_Result = res_q;
  assign Rsp_Zero   = z_q;
  assign Rsp_Carry  = c_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      id_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            a_q   <= Req_A[idx*WIDTH +: WIDTH];
            b_q   <= Req_B[idx*WIDTH +: WIDTH];
            op_q  <= Req_Opcode[idx*3 +: 3];
            id_q  <= idx;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          res_q <= Alu_Result;
          z_q   <= Alu_Zero;
          c_q   <= Alu_Carry;
          ptr   <= (id_q == IW'(NREQ - 1)) ?
                   '0 : id_q + 1'b1;
          state <= RESP;
        end
        RESP: begin
          if (Rsp_Ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Grant_Count <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (Req_Ready[i] &&
            Grant_Count[i*8 +: 8] != 8'hff)
          Grant_Count[i*8 +: 8] <=
            Grant_Count[i*8 +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: bench-side ALU, transaction model,
// directed cases and randomized traffic.
module tb_alu_arbiter;

  localparam int N = 4;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [3:0]   Req_Valid;
  logic [3:0]   Req_Ready;
  logic [15:0]  Req_A;
  logic [15:0]  Req_B;
  logic [11:0]  Req_Opcode;
  logic [3:0]   Alu_A;
  logic [3:0]   Alu_B;
  logic [2:0]   Alu_Opcode;
  logic [3:0]   Alu_Result;
  logic         Alu_Zero;
  logic         Alu_Carry;
  logic         Rsp_Valid;
  logic         Rsp_Ready;
  logic [1:0]   Rsp_Id;
  logic [3:0]   Rsp_Result;
  logic         Rsp_Zero;
  logic         Rsp_Carry;
`ifdef ALU_ARB_STATS_EN
  logic [31:0]  Grant_Count;
`endif

  alu_arbiter #(
    .NREQ(4),
    .WIDTH(4)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Req_Valid(Req_Valid),
    .Req_Ready(Req_Ready),
    .Req_A(Req_A),
    .Req_B(Req_B),
    .Req_Opcode(Req_Opcode),
    .Alu_A(Alu_A),
    .Alu_B(Alu_B),
    .Alu_Opcode(Alu_Opcode),
    .Alu_Result(Alu_Result),
    .Alu_Zero(Alu_Zero),
    .Alu_Carry(Alu_Carry),
    .Rsp_Valid(Rsp_Valid),
    .Rsp_Ready(Rsp_Ready),
    .Rsp_Id(Rsp_Id),
    .Rsp_Result(Rsp_Result),
    .Rsp_Zero(Rsp_Zero),
    .Rsp_Carry(Rsp_Carry)
`ifdef ALU_ARB_STATS_EN
    ,
    .Grant_Count(Grant_Count)
`endif
  );

  always #5 Clk = ~Clk;

  // Bench ALU: {carry, zero, result}; SUB carry is the borrow
  function automatic logic [5:0] alu_f(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] op
  );
    logic [4:0] s;
    case (op)
      3'd0:    s = {1'b0, a} + {1'b0, b};
      3'd1:    s = {1'b0, a} - {1'b0, b};
      3'd2:    s = {1'b0, a & b};
      3'd3:    s = {1'b0, a | b};
      3'd4:    s = {1'b0, ~a};
      default: s = {1'b0, a ^ b};
    endcase
    return {s[4], s[3:0] == 4'd0, s[3:0]};
  endfunction

  always_comb
    {Alu_Carry, Alu_Zero, Alu_Result} =
      alu_f(Alu_A, Alu_B, Alu_Opcode);

  int ncmp = 0;
  int nfail = 0;

  // Reference model: phase 0 waiting, 1 on ALU, 2 holding response
  int         mph = 0;
  int         mptr = 0;
  int         mid = 0;
  logic [3:0] ma = '0;
  logic [3:0] mb = '0;
  logic [2:0] mop = '0;
  logic [3:0] mres = '0;
  logic       mz = 1'b0;
  logic       mc = 1'b0;
  int         mcnt [N];
  int         last_grant = -1;
  int         cyc = 0;

  task automatic chk(input string n, input int got,
                     input int exp);
    ncmp++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)",
               n, got, exp, cyc);
    end
  endtask

  task automatic step();
    int         w;
    int         j;
    int         er;
    logic [5:0] r;
    @(negedge Clk);
    w = -1;
    if (Rst_n && mph == 0)
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (w < 0 && Req_Valid[j]) w = j;
      end
    er = (w >= 0) ? (1 << w) : 0;
    chk("req_ready", int'(Req_Ready), er);
    last_grant = w;
    if (Rst_n) begin
      chk("rsp_valid", int'(Rsp_Valid), int'(mph == 2));
      chk("alu_a", int'(Alu_A), int'(ma));
      chk("alu_b", int'(Alu_B), int'(mb));
      chk("alu_op", int'(Alu_Opcode), int'(mop));
      chk("rsp_result", int'(Rsp_Result), int'(mres));
      chk("rsp_zero", int'(Rsp_Zero), int'(mz));
      chk("rsp_carry", int'(Rsp_Carry), int'(mc));
      if (mph == 2) chk("rsp_id", int'(Rsp_Id), mid);
`ifdef ALU_ARB_STATS_EN
      for (int i = 0; i < N; i++)
        chk($sformatf("cnt%0d", i),
            int'(Grant_Count[i*8 +: 8]), mcnt[i]);
`endif
    end
    if (!Rst_n) begin
      mph = 0; mptr = 0; mid = 0;
      ma = '0; mb = '0; mop = '0;
      mres = '0; mz = 1'b0; mc = 1'b0;
      for (int i = 0; i < N; i++) mcnt[i] = 0;
    end else if (mph == 0) begin
      if (w >= 0) begin
        ma  = Req_A[w*4 +: 4];
        mb  = Req_B[w*4 +: 4];
        mop = Req_Opcode[w*3 +: 3];
        mid = w;
        mph = 1;
        if (mcnt[w] < 255) mcnt[w]++;
      end
    end else if (mph == 1) begin
      r    = alu_f(ma, mb, mop);
      mres = r[3:0];
      mz   = r[4];
      mc   = r[5];
      mptr = (mid + 1) % N;
      mph  = 2;
    end else if (Rsp_Ready) begin
      mph = 0;
    end
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int r, input logic [3:0] a,
                         input logic [3:0] b,
                         input logic [2:0] op);
    Req_A[r*4 +: 4]      = a;
    Req_B[r*4 +: 4]      = b;
    Req_Opcode[r*3 +: 3] = op;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
  endtask

  task automatic run_one(input int r, input logic [3:0] a,
                         input logic [3:0] b,
                         input logic [2:0] op,
                         input int stall,
                         input int eres, input int ez,
                         input int ec);
    int n;
    set_req(r, a, b, op);
    Req_Valid = 4'(1 << r);
    Rsp_Ready = (stall == 0);
    n = 0;
    do begin
      step();
      n++;
    end while (last_grant != r && n < 20);
    chk("accept", last_grant, r);
    Req_Valid = '0;
    chk("issue_no_rsp", int'(Rsp_Valid), 0);
    chk("issue_alu_a", int'(Alu_A), int'(a));
    step();
    if (stall > 0) Req_Valid = 4'(~(1 << r));
    chk("n2_rsp_valid", int'(Rsp_Valid), 1);
    chk("n2_rsp_id", int'(Rsp_Id), r);
    chk("n2_result", int'(Rsp_Result), eres);
    chk("n2_zero", int'(Rsp_Zero), ez);
    chk("n2_carry", int'(Rsp_Carry), ec);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_valid", int'(Rsp_Valid), 1);
      chk("stall_result", int'(Rsp_Result), eres);
      chk("stall_id", int'(Rsp_Id), r);
      chk("stall_ready", int'(Req_Ready), 0);
    end
    if (stall > 0) begin
      Rsp_Ready = 1'b1;
      step();
      chk("reidle_ready", int'(|Req_Ready), 1);
      Req_Valid = '0;
    end
    step();
  endtask

  initial begin
    int gq[$];
    int gc[$];
    int n;
    logic [3:0] pend;

    for (int i = 0; i < N; i++) mcnt[i] = 0;
    Rst_n      = 1'b0;
    Req_Valid  = '0;
    Req_A      = '0;
    Req_B      = '0;
    Req_Opcode = '0;
    Rsp_Ready  = 1'b1;
    #1;
    do_reset();
    chk("reset_alu_a", int'(Alu_A), 0);
    chk("reset_rsp_valid", int'(Rsp_Valid), 0);

    run_one(0, 4'b0011, 4'b0101, 3'b000, 0, 8, 0, 0);
    run_one(2, 4'b0111, 4'b0010, 3'b001, 5, 5, 0, 0);
    run_one(1, 4'b1111, 4'b0001, 3'b000, 0, 0, 1, 1);
    run_one(3, 4'b1010, 4'b0000, 3'b100, 0, 5, 0, 0);
    run_one(1, 4'b1100, 4'b1010, 3'b110, 0, 6, 0, 0);

    // Round-robin order from Ptr=0
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 4'($urandom), 4'($urandom), 3'($urandom));
    Req_Valid = 4'hf;
    Rsp_Ready = 1'b1;
    n = 0;
    while (gq.size() < 5 && n < 40) begin
      step();
      n++;
      if (last_grant >= 0) begin
        gq.push_back(last_grant);
        gc.push_back(cyc);
      end
    end
    Req_Valid = '0;
    chk("rr_count", gq.size(), 5);
    if (gq.size() == 5) begin
      chk("rr_g0", gq[0], 0);
      chk("rr_g1", gq[1], 1);
      chk("rr_g2", gq[2], 2);
      chk("rr_g3", gq[3], 3);
      chk("rr_g4", gq[4], 0);
      for (int i = 1; i < 5; i++)
        chk("rr_spacing", gc[i] - gc[i-1], 3);
    end
    for (int i = 0; i < 3; i++) step();

    // Reset while in ISSUE discards the operation
    run_one(2, 4'd1, 4'd1, 3'b000, 0, 2, 0, 0);
    set_req(1, 4'd9, 4'd3, 3'b001);
    Req_Valid = 4'b0010;
    n = 0;
    do begin
      step();
      n++;
    end while (last_grant != 1 && n < 20);
    chk("mid_accept", last_grant, 1);
    Req_Valid = '0;
    do_reset();
    chk("mid_rsp_valid", int'(Rsp_Valid), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_rsp", int'(Rsp_Valid), 0);
    end
    Req_Valid = 4'hf;
    step();
    chk("mid_ptr0", last_grant, 0);
    Req_Valid = '0;
    for (int i = 0; i < 3; i++) step();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    set_req(0, 4'd2, 4'd2, 3'b010);
    Req_Valid = 4'b0001;
    Rsp_Ready = 1'b1;
    n = 0;
    for (int i = 0; i < 1000 && n < 300; i++) begin
      step();
      if (last_grant == 0) n++;
    end
    Req_Valid = '0;
    chk("stats_grants", n, 300);
    chk("stats_cnt0", int'(Grant_Count[7:0]), 255);
    chk("stats_rest", int'(Grant_Count[31:8]), 0);
    for (int i = 0; i < 3; i++) step();
    do_reset();
    chk("stats_clear", int'(Grant_Count), 0);
`endif

    // Randomized traffic with occasional resets
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      if (last_grant >= 0) pend[last_grant] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if ($urandom_range(15) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          set_req(i, 4'($urandom), 4'($urandom),
                  3'($urandom));
        end
      end
      Req_Valid = pend;
      Rsp_Ready = ($urandom_range(2) != 0);
      Rst_n     = ($urandom_range(149) != 0);
      step();
    end
    Rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 4-bit ALU (ADD/SUB/AND/OR/NOT, Zero and Carry flags) between NREQ requesters. It accepts operations through per-requester valid/ready handshakes and grants them round-robin. The selected operands are registered and driven onto the shared ALU. Each result and its flags are returned on a single response channel, tagged with the requester ID.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8
- WIDTH, 4: operand/result width; must match the ALU

Ports:
- Clk  in  1  clock; all state changes on the rising edge
- Rst_n  in  1  synchronous, active-low reset
- Req_Valid  in  NREQ  request pending, one bit per requester
- Req_Ready  out  NREQ  one-hot accept strobe
- Req_A  in  NREQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH]
- Req_B  in  NREQ*WIDTH  operand B, sliced the same way as Req_A
- Req_Opcode  in  NREQ*3  opcode; requester i uses slice [i*3 +: 3]
- Alu_A, Alu_B  out  WIDTH  operands to the shared ALU
- Alu_Opcode  out  3  opcode to the shared ALU
- Alu_Result  in  WIDTH  ALU result
- Alu_Zero, Alu_Carry  in  1  ALU flags
- Rsp_Valid  out  1  response available
- Rsp_Ready  in  1  consumer accepts the response
- Rsp_Id  out  $clog2(NREQ)  index of the requester that issued the operation
- Rsp_Result  out  WIDTH  captured result
- Rsp_Zero, Rsp_Carry  out  1  captured flags

## Operation
- FSM states and transitions:
  - IDLE: if any Req_Valid is high, pick the winner by round-robin and go to ISSUE.
  - ISSUE: go to RESP unconditionally.
  - RESP: go to IDLE on Rsp_Valid && Rsp_Ready.
- Round-robin selection: search starts at pointer Ptr and takes the first requester with Req_Valid high, wrapping from NREQ-1 to 0. Ptr resets to 0.
- Acceptance in IDLE: Req_Ready[winner] is asserted combinationally in the same cycle. The winner's A, B and Opcode are captured into operand registers, and the winner is saved in Id_q. Req_Ready is all-zero in every other state and cycle.
- ISSUE:
  - Alu_A, Alu_B and Alu_Opcode are driven from the operand registers.
  - Alu_Result, Alu_Zero and Alu_Carry are captured into the response registers at the end of the cycle.
  - Ptr is updated to (Id_q+1) mod NREQ.
- RESP: Rsp_Valid=1. Rsp_* outputs are held stable until the handshake completes.
- Outside ISSUE, the Alu_* outputs hold the last operand-register values; they are not glitched to zero.
- Opcodes 101–111 are passed through unchecked; the response reflects whatever the ALU returns.
- Requester-side rules:
  - A requester keeps Req_Valid asserted and its operands stable until it sees Req_Ready.
  - Deasserting Req_Valid before acceptance is permitted; that requester is simply not considered.
- Reset values:
  - State=IDLE, Ptr=0, Id_q=0.
  - Rsp_Valid=0; Rsp_Result, Rsp_Zero and Rsp_Carry =0.
  - Operand registers =0, so Alu_A, Alu_B and Alu_Opcode are 0.
  - Req_Ready=0 during the reset cycle.
- Reset mid-operation: a transaction in ISSUE or RESP is discarded. No response is produced, and the requester is not re-serviced unless it asserts Req_Valid again.

## Timing
- Request to response: accepted in cycle N (IDLE), ALU evaluated in N+1 (ISSUE), Rsp_Valid=1 from N+2.
- Minimum occupancy is 3 cycles per operation. A new request can be accepted the cycle after the response handshake.
- Rsp_Ready low holds the block in RESP indefinitely; no new requests are accepted meanwhile.
- If Rsp_Valid && Rsp_Ready and new Req_Valid occur together, the response completes and the new request waits for IDLE in the next cycle.
- Shared-ALU path: the ALU is combinational from the Alu_* registers to the capture registers. The combined delay of operand register → ALU → capture must fit in one Clk period.

## Configuration
- ALU_ARB_STATS_EN defined:
  - Adds output Grant_Count, NREQ*8 bits: one saturating 8-bit counter per requester, in slices [i*8 +: 8].
  - A requester's counter increments on each of its Req_Ready pulses.
  - Counters saturate at 255 and clear to 0 on reset.
- ALU_ARB_STATS_EN undefined: Grant_Count port and counters are absent; all other behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_NOT=3'b100
  - arb_state_t enum {IDLE, ISSUE, RESP}
- Sub-module rr_arbiter is combinational. It takes NREQ request bits and Ptr, and returns the one-hot grant, the encoded index and an any-valid signal. It is reusable for other shared resources.
- The top level holds the FSM, Ptr, the operand and response registers, and the optional stats counters.

## Test plan
- Req 0 only, A=0011, B=0101, Opcode=000, accepted cycle N → Rsp_Valid at N+2, Rsp_Id=0, Result=1000, Zero=0, Carry=0.
- All four Req_Valid high continuously, Rsp_Ready=1, Ptr=0 after reset → grant order 0,1,2,3,0; each Req_Ready is one-hot, one grant every 3 cycles.
- Req 2 SUB 0111−0010, Rsp_Ready held low 5 cycles → Rsp_Valid, Rsp_Result=0101 and Rsp_Id=2 stay stable; Req_Ready stays 0 throughout; IDLE is re-entered the cycle after Rsp_Ready rises.
- Req 1 ADD 1111+0001 → Rsp_Result=0000, Zero=1, Carry=1; Req 3 NOT 1010 → Rsp_Result=0101.
- Rst_n low for one cycle while in ISSUE → next cycle State=IDLE, Rsp_Valid=0, Ptr=0, no response ever issued for that operation.
- With ALU_ARB_STATS_EN: 300 back-to-back grants to req 0 → Grant_Count[7:0]=255; other counters 0; all counters 0 after reset.
